// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register file write port, with clear sequencing.
// Optional contention counter built when REGARB_STATS_EN is defined.
module regfile_write_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 3,
  parameter int DW   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               clr_req,
  output logic               clr_busy,
  output logic               rf_write,
  output logic [AW-1:0]      rf_inaddr,
  output logic [DW-1:0]      rf_in,
  output logic               rf_clear,
  output logic [1:0]         gnt_id,
  output logic               idle,
  output logic [15:0]        conflict_cnt
);

  typedef enum logic {ARB, CLEAR} state_e;

  state_e          state_q, state_d;
  logic [1:0]      last_q, last_d;
  logic            rf_write_q, rf_write_d;
  logic [AW-1:0]   rf_inaddr_q, rf_inaddr_d;
  logic [DW-1:0]   rf_in_q, rf_in_d;
  logic            rf_clear_q, rf_clear_d;
  logic            clr_busy_q, clr_busy_d;
  logic [1:0]      gnt_id_q, gnt_id_d;

  logic            found;
  logic [1:0]      gnt_idx, cand;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  // Scan from the slot after the last winner, wrapping around.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (state_q == ARB && !clr_req) begin
      for (int k = 1; k <= NREQ; k++) begin
        cand = 2'((int'(last_q) + k) % NREQ);
        if (!found && req_valid[cand]) begin
          found   = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  always_comb begin
    req_ready          = '0;
    req_ready[gnt_idx] = found;
  end

  assign sel_addr = req_addr[gnt_idx*AW +: AW];
  assign sel_data = req_data[gnt_idx*DW +: DW];

  always_comb begin
    state_d     = ARB;
    last_d      = last_q;
    rf_write_d  = 1'b0;
    rf_inaddr_d = rf_inaddr_q;
    rf_in_d     = rf_in_q;
    rf_clear_d  = 1'b0;
    clr_busy_d  = 1'b0;
    gnt_id_d    = gnt_id_q;
    if (state_q == ARB && clr_req) begin
      state_d    = CLEAR;
      rf_clear_d = 1'b1;
      clr_busy_d = 1'b1;
    end else if (found) begin
      // Register 0 is hardwired: handshake completes but no write strobe.
      last_d      = gnt_idx;
      rf_write_d  = (sel_addr != '0);
      rf_inaddr_d = sel_addr;
      rf_in_d     = sel_data;
      gnt_id_d    = gnt_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB;
      last_q      <= 2'(NREQ - 1);
      rf_write_q  <= 1'b0;
      rf_inaddr_q <= '0;
      rf_in_q     <= '0;
      rf_clear_q  <= 1'b0;
      clr_busy_q  <= 1'b0;
      gnt_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      rf_write_q  <= rf_write_d;
      rf_inaddr_q <= rf_inaddr_d;
      rf_in_q     <= rf_in_d;
      rf_clear_q  <= rf_clear_d;
      clr_busy_q  <= clr_busy_d;
      gnt_id_q    <= gnt_id_d;
    end
  end

  assign rf_write  = rf_write_q;
  assign rf_inaddr = rf_inaddr_q;
  assign rf_in     = rf_in_q;
  assign rf_clear  = rf_clear_q;
  assign clr_busy  = clr_busy_q;
  assign gnt_id    = gnt_id_q;
  assign idle      = (state_q == ARB) && !(|req_valid);

`ifdef REGARB_STATS_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;
  logic [2:0]  nvalid;

  always_comb begin
    nvalid = '0;
    for (int i = 0; i < NREQ; i++) nvalid = nvalid + 3'(req_valid[i]);
    conflict_cnt_d = conflict_cnt_q;
    if (state_q == ARB && !clr_req && nvalid >= 3'd2 && conflict_cnt_q != 16'hFFFF)
      conflict_cnt_d = conflict_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) conflict_cnt_q <= '0;
    else        conflict_cnt_q <= conflict_cnt_d;
  end

  assign conflict_cnt = conflict_cnt_q;
`else
  assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: per-cycle reference model plus directed literal checks.
module tb_regfile_write_arbiter;
  localparam int NREQ = 3, AW = 3, DW = 16;

  logic               clk = 1'b0, rst_n = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]    req_ready;
  logic               clr_req = 1'b0, clr_busy, rf_write, rf_clear, idle;
  logic [AW-1:0]      rf_inaddr;
  logic [DW-1:0]      rf_in;
  logic [1:0]         gnt_id;
  logic [15:0]        conflict_cnt;

  regfile_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .clr_req(clr_req),
    .clr_busy(clr_busy), .rf_write(rf_write), .rf_inaddr(rf_inaddr), .rf_in(rf_in),
    .rf_clear(rf_clear), .gnt_id(gnt_id), .idle(idle), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the outputs must show in the current cycle.
  int          m_last = NREQ - 1;
  bit          m_clear = 0, m_write = 0;
  int          m_addr = 0, m_data = 0, m_gnt = 0, m_cnt = 0;
  int          n_last, n_addr, n_data, n_gnt, n_cnt;
  bit          n_clear, n_write;

  task automatic model_reset();
    m_last = NREQ - 1; m_clear = 0; m_write = 0;
    m_addr = 0; m_data = 0; m_gnt = 0; m_cnt = 0;
  endtask

  always @(negedge clk) begin
    int g, nv;
    logic [NREQ-1:0] exp_rdy;
    if (!rst_n) model_reset();
    g = -1;
    if (!m_clear && !clr_req)
      for (int k = 1; k <= NREQ; k++)
        if (g < 0 && req_valid[(m_last + k) % NREQ]) g = (m_last + k) % NREQ;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    nv = $countones(req_valid);
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("idle", 32'(idle), 32'(!m_clear && nv == 0));
    chk("rf_write", 32'(rf_write), 32'(m_write));
    chk("rf_clear", 32'(rf_clear), 32'(m_clear));
    chk("clr_busy", 32'(clr_busy), 32'(m_clear));
    chk("rf_inaddr", 32'(rf_inaddr), 32'(m_addr));
    chk("rf_in", 32'(rf_in), 32'(m_data));
    chk("gnt_id", 32'(gnt_id), 32'(m_gnt));
`ifdef REGARB_STATS_EN
    chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
`else
    chk("conflict_cnt", 32'(conflict_cnt), 32'd0);
`endif
    n_clear = !m_clear && clr_req;
    n_write = 0; n_last = m_last; n_addr = m_addr; n_data = m_data; n_gnt = m_gnt;
    n_cnt = m_cnt;
    if (g >= 0) begin
      n_addr = int'(req_addr[g*AW +: AW]);
      n_data = int'(req_data[g*DW +: DW]);
      n_write = (n_addr != 0);
      n_gnt = g; n_last = g;
    end
    if (!m_clear && !clr_req && nv >= 2 && m_cnt < 65535) n_cnt = m_cnt + 1;
    if (!rst_n) begin
      n_clear = 0; n_write = 0; n_last = NREQ - 1; n_addr = 0; n_data = 0;
      n_gnt = 0; n_cnt = 0;
    end
  end

  always @(posedge clk) begin
    m_clear = n_clear; m_write = n_write; m_last = n_last; m_addr = n_addr;
    m_data = n_data; m_gnt = n_gnt; m_cnt = n_cnt;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  initial begin
    // Reset state
    step(); step();
    chk("rst rf_write", 32'(rf_write), 0);
    chk("rst rf_inaddr", 32'(rf_inaddr), 0);
    chk("rst gnt_id", 32'(gnt_id), 0);
    #1 rst_n = 1'b1;

    // All three held: 0,1,2,0,1,2
    set_req(0, 3'd1, 16'hA000); set_req(1, 3'd2, 16'hA001); set_req(2, 3'd3, 16'hA002);
    req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      #1 chk("rr order", 32'(req_ready), 32'(1 << (c % 3)));
      step();
      chk("rr write pulse", 32'(rf_write), 1);
      chk("rr gnt_id", 32'(gnt_id), 32'(c % 3));
    end
    req_valid = '0;
    step();

    // Requester 1 alone, addr 5
    set_req(1, 3'd5, 16'hBEEF);
    req_valid = 3'b010;
    #1 chk("r1 ready", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    chk("r1 rf_write", 32'(rf_write), 1);
    chk("r1 rf_inaddr", 32'(rf_inaddr), 5);
    chk("r1 rf_in", 32'(rf_in), 32'hBEEF);
    chk("r1 gnt_id", 32'(gnt_id), 1);
    step();

    // Register 0 write: handshake, no strobe, pointer advances
    set_req(0, 3'd0, 16'h1234);
    req_valid = 3'b001;
    #1 chk("r0 ready", 32'(req_ready), 32'h1);
    step();
    chk("r0 rf_write", 32'(rf_write), 0);
    chk("r0 rf_in", 32'(rf_in), 32'h1234);
    set_req(1, 3'd6, 16'h5678);
    req_valid = 3'b011;
    #1 chk("r0 next grant", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    step();

    // Clear beats grants
    set_req(0, 3'd4, 16'hC0DE);
    req_valid = 3'b011; clr_req = 1'b1;
    #1 chk("clr no ready", 32'(req_ready), 0);
    step();
    clr_req = 1'b0;
    chk("clr rf_clear", 32'(rf_clear), 1);
    chk("clr busy", 32'(clr_busy), 1);
    chk("clr rf_write", 32'(rf_write), 0);
    step();
    chk("post-clr grant", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    step();

    // Reset mid-write with pointer at 2
    set_req(2, 3'd7, 16'h7777);
    req_valid = 3'b100;
    step();
    chk("pre-rst rf_write", 32'(rf_write), 1);
    req_valid = 3'b111;
    #1 rst_n = 1'b0;
    #1 chk("mid-rst rf_write", 32'(rf_write), 0);
    chk("mid-rst rf_in", 32'(rf_in), 0);
    chk("mid-rst gnt_id", 32'(gnt_id), 0);
    @(posedge clk); #2 rst_n = 1'b1;
    #1 chk("post-rst grant", 32'(req_ready), 32'h1);
    req_valid = '0;
    step();

    // Contention: 11 cycles of two valid, one carries clr_req
    req_valid = 3'b011;
    for (int c = 0; c < 11; c++) begin
      clr_req = (c == 2);
      step();
    end
    clr_req = 1'b0; req_valid = '0;
    step();
`ifdef REGARB_STATS_EN
    chk("conflict_cnt lit", 32'(conflict_cnt), 9);
`else
    chk("conflict_cnt lit", 32'(conflict_cnt), 0);
`endif
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
